reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer between the instruction unit and the register file.
//  Allocates a ROB id per issued instruction and holds results broadcast on the CDB.
//  Answers operand look-ups for renamed registers.
//  Retires the head in program order, driving the register-file write port and the store-commit pulse.
//  A mispredicted branch at retirement flushes the ROB and raises the global clear.
// PARAMETERS
//  ROB_WIDTH   4   id width; DEPTH = 2**ROB_WIDTH entries (16)
// PORTS
//  clockIn         in   1          single clock, rising edge
//  resetIn         in   1          asynchronous, active-low reset
//  readyIn         in   1          global enable; low = hold all state
//  issueValid      in   1          instruction unit presents an entry
//  issueType       in   2          00 NONE, 01 REG, 10 STORE, 11 BRANCH
//  issueRd         in   5          destination register (REG only)
//  issueReadyNow   in   1          value already known (LUI/AUIPC/JAL link)
//  issueValue      in   32         value when issueReadyNow
//  issuePredTaken  in   1          predicted direction (BRANCH)
//  issueAltPc      in   32         redirect PC if prediction wrong
//  issueAccept     out  1          entry taken this cycle
//  allocId         out  ROB_WIDTH  id of the entry being allocated (= tail)
//  robFull         out  1          count == DEPTH
//  query1Id/query2Id      in   ROB_WIDTH  operand look-up ids
//  query1Ready/query2Ready out 1          entry holds a result
//  query1Value/query2Value out 32         that result
//  cdbValid        in   1          result broadcast
//  cdbId           in   ROB_WIDTH  producing entry
//  cdbValue        in   32         result
//  cdbTaken        in   1          actual direction (BRANCH)
//  writeFlag       out  1          register-file commit strobe
//  robId           out  ROB_WIDTH  committing id
//  writeAddr       out  5          committing rd
//  writeValue      out  32         committing value
//  storeCommit     out  1          head STORE retires; LSB may write memory
//  clearOut        out  1          one-cycle flush pulse to all units
//  clearPc         out  32         fetch restart PC, valid with clearOut
// BEHAVIOUR
//  Reset (resetIn=0, async):
//   - head = tail = 0, count = 0, all valid/ready bits 0.
//   - clearOut = 0, clearPc = 0. All combinational outputs read 0 / robFull = 0.
//  Hold: when readyIn = 0, nothing changes and writeFlag/storeCommit/issueAccept are 0.
//  Issue:
//   - issueAccept = issueValid & readyIn & !robFull & !clearOut.
//   - robFull is evaluated before the same-cycle retire, so no issue into a freeing slot.
//   - On accept, entry[tail] is written and tail = tail+1 mod DEPTH (wraps 15 -> 0).
//   - The new entry has valid = 1 and ready = issueReadyNow; a NONE entry is ready = 1.
//   - allocId = tail is combinational and is the id the register file records as rdDest.
//  CDB:
//   - When cdbValid and entry[cdbId] is valid, set ready = 1 and store cdbValue and cdbTaken.
//   - A CDB write to an invalid (flushed) entry is ignored.
//  Query (combinational): the ready/value of entry[queryNId].
//   - Bypass: if cdbValid and cdbId == queryNId, return ready = 1 and cdbValue.
//  Retire (combinational outputs, state updates on the edge) when readyIn & count > 0 & entry[head].ready:
//   - REG: writeFlag = 1 with robId = head, writeAddr = rd, writeValue = value; rd = x0 still commits.
//   - STORE: storeCommit = 1.
//   - BRANCH: no write.
//   - head = head+1, count decrements. One retire per cycle, and no CDB-to-retire bypass:
//     an entry made ready by the CDB in cycle N retires no earlier than N+1.
//  Count: count(ROB_WIDTH+1 bits) += accept - retire. Simultaneous issue and retire leaves count unchanged.
//  Mispredict: a BRANCH retires with taken != predTaken. On that edge:
//   - head = tail = 0, count = 0, all valid bits cleared, and the same-cycle issue is discarded.
//   - clearOut = 1 and clearPc = altPc for exactly the next cycle.
//   - While clearOut = 1: no issue, no retire; CDB writes are ignored (all entries invalid).
//  State machine (2 states):
//   - RUN -> FLUSH on mispredict retire.
//   - FLUSH -> RUN after one cycle unconditionally.
//   - readyIn = 0 holds FLUSH.
//  Reset mid-operation wins over everything and is asynchronous.
// STRUCTURE
//  - Shared header rob_defs.vh: ROB_TYPE_NONE/REG/STORE/BRANCH codes, ROB_WIDTH default.
//  - No sub-module. Entry arrays are flat regs:
//    type, rd, value, ready, valid, predTaken, taken, altPc.
// TESTING
//  1. Reset low mid-run, then release -> count 0, robFull 0, allocId 0, all strobes 0.
//  2. Issue REG rd=5, allocId=0; CDB id 0 value 0x1234 -> next cycle writeFlag=1,
//     writeAddr=5, writeValue=0x1234, robId=0.
//  3. Issue 16 entries -> robFull=1 and the 17th issueAccept=0.
//     Retire head with issueValid=1 in the same cycle -> still no accept.
//     Next cycle accepts at allocId=0 (wrap).
//  4. Out-of-order CDB to ids 2, 1, 0 -> retires in order 0, 1, 2 over three cycles.
//  5. BRANCH predTaken=0, altPc=0x100, followed by 3 REG entries; CDB taken=1 ->
//     at branch retire, clearOut=1 one cycle, clearPc=0x100, count 0, no REG commits.
//  6. Query id 3 in the same cycle as CDB id 3 value 0xABCD -> query1Ready=1,
//     query1Value=0xABCD; with readyIn=0 the entry stays unretired.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions.
// Entry type codes and the default id width.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;

    localparam logic [1:0] ROB_TYPE_NONE   = 2'b00;
    localparam logic [1:0] ROB_TYPE_REG    = 2'b01;
    localparam logic [1:0] ROB_TYPE_STORE  = 2'b10;
    localparam logic [1:0] ROB_TYPE_BRANCH = 2'b11;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer with CDB capture, operand look-up,
// in-order retirement and mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issueReadyNow,
    input  logic [31:0]          issueValue,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic                 issueAccept,
    output logic [ROB_WIDTH-1:0] allocId,
    output logic                 robFull,
    input  logic [ROB_WIDTH-1:0] query1Id,
    input  logic [ROB_WIDTH-1:0] query2Id,
    output logic                 query1Ready,
    output logic                 query2Ready,
    output logic [31:0]          query1Value,
    output logic [31:0]          query2Value,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbId,
    input  logic [31:0]          cdbValue,
    input  logic                 cdbTaken,
    output logic                 writeFlag,
    output logic [ROB_WIDTH-1:0] robId,
    output logic [4:0]           writeAddr,
    output logic [31:0]          writeValue,
    output logic                 storeCommit,
    output logic                 clearOut,
    output logic [31:0]          clearPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]           state;
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic [1:0]  ent_type  [DEPTH];
    logic [4:0]  ent_rd    [DEPTH];
    logic [31:0] ent_value [DEPTH];
    logic        ent_ready [DEPTH];
    logic        ent_valid [DEPTH];
    logic        ent_pred  [DEPTH];
    logic        ent_taken [DEPTH];
    logic [31:0] ent_alt   [DEPTH];

    logic retire;
    logic mispredict;
    logic [1:0] head_type;

    assign clearOut    = (state == ST_FLUSH);
    assign robFull     = (count == FULL_COUNT);
    assign allocId     = tail;
    assign issueAccept = issueValid & readyIn & ~robFull & ~clearOut;

    assign head_type = ent_type[head];
    assign retire    = readyIn & ~clearOut & (count != '0) & ent_ready[head];

    assign writeFlag   = retire & (head_type == ROB_TYPE_REG);
    assign storeCommit = retire & (head_type == ROB_TYPE_STORE);
    assign mispredict  = retire & (head_type == ROB_TYPE_BRANCH)
                       & (ent_taken[head] != ent_pred[head]);

    assign robId      = head;
    assign writeAddr  = writeFlag ? ent_rd[head] : 5'd0;
    assign writeValue = writeFlag ? ent_value[head] : 32'd0;

    // Operand look-up with same-cycle CDB bypass
    always_comb begin
        query1Ready = ent_ready[query1Id];
        query1Value = ent_ready[query1Id] ? ent_value[query1Id] : 32'd0;
        query2Ready = ent_ready[query2Id];
        query2Value = ent_ready[query2Id] ? ent_value[query2Id] : 32'd0;
        if (cdbValid && (cdbId == query1Id)) begin
            query1Ready = 1'b1;
            query1Value = cdbValue;
        end
        if (cdbValid && (cdbId == query2Id)) begin
            query2Ready = 1'b1;
            query2Value = cdbValue;
        end
    end

    // Pointers, entry arrays, flush state machine
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state   <= ST_RUN;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            clearPc <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_type[i]  <= ROB_TYPE_NONE;
                ent_rd[i]    <= 5'd0;
                ent_value[i] <= 32'd0;
                ent_ready[i] <= 1'b0;
                ent_valid[i] <= 1'b0;
                ent_pred[i]  <= 1'b0;
                ent_taken[i] <= 1'b0;
                ent_alt[i]   <= 32'd0;
            end
        end else if (readyIn) begin
            if (state == ST_FLUSH) begin
                state <= ST_RUN;
            end else if (mispredict) begin
                state   <= ST_FLUSH;
                clearPc <= ent_alt[head];
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_valid[i] <= 1'b0;
                    ent_ready[i] <= 1'b0;
                end
            end else begin
                if (cdbValid && ent_valid[cdbId]) begin
                    ent_ready[cdbId] <= 1'b1;
                    ent_value[cdbId] <= cdbValue;
                    ent_taken[cdbId] <= cdbTaken;
                end
                if (retire) begin
                    ent_valid[head] <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                if (issueAccept) begin
                    ent_type[tail]  <= issueType;
                    ent_rd[tail]    <= issueRd;
                    ent_value[tail] <= issueValue;
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= issueReadyNow
                                     | (issueType == ROB_TYPE_NONE);
                    ent_pred[tail]  <= issuePredTaken;
                    ent_taken[tail] <= 1'b0;
                    ent_alt[tail]   <= issueAltPc;
                    tail            <= tail + 1'b1;
                end
                count <= count
                       + {{ROB_WIDTH{1'b0}}, issueAccept}
                       - {{ROB_WIDTH{1'b0}}, retire};
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer against a queue-based
// reference model of program-order retirement.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int EV_REG = 0;
    localparam int EV_STORE = 1;
    localparam int EV_CLEAR = 2;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        readyIn = 1'b0;
    logic        issueValid = 1'b0;
    logic [1:0]  issueType = 2'b00;
    logic [4:0]  issueRd = 5'd0;
    logic        issueReadyNow = 1'b0;
    logic [31:0] issueValue = 32'd0;
    logic        issuePredTaken = 1'b0;
    logic [31:0] issueAltPc = 32'd0;
    logic        issueAccept;
    logic [3:0]  allocId;
    logic        robFull;
    logic [3:0]  query1Id = 4'd0;
    logic [3:0]  query2Id = 4'd0;
    logic        query1Ready, query2Ready;
    logic [31:0] query1Value, query2Value;
    logic        cdbValid = 1'b0;
    logic [3:0]  cdbId = 4'd0;
    logic [31:0] cdbValue = 32'd0;
    logic        cdbTaken = 1'b0;
    logic        writeFlag;
    logic [3:0]  robId;
    logic [4:0]  writeAddr;
    logic [31:0] writeValue;
    logic        storeCommit;
    logic        clearOut;
    logic [31:0] clearPc;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
        .issueValid(issueValid), .issueType(issueType),
        .issueRd(issueRd), .issueReadyNow(issueReadyNow),
        .issueValue(issueValue), .issuePredTaken(issuePredTaken),
        .issueAltPc(issueAltPc), .issueAccept(issueAccept),
        .allocId(allocId), .robFull(robFull),
        .query1Id(query1Id), .query2Id(query2Id),
        .query1Ready(query1Ready), .query2Ready(query2Ready),
        .query1Value(query1Value), .query2Value(query2Value),
        .cdbValid(cdbValid), .cdbId(cdbId), .cdbValue(cdbValue),
        .cdbTaken(cdbTaken), .writeFlag(writeFlag), .robId(robId),
        .writeAddr(writeAddr), .writeValue(writeValue),
        .storeCommit(storeCommit), .clearOut(clearOut),
        .clearPc(clearPc)
    );

    always #5 clockIn = ~clockIn;

    typedef struct {
        int          id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          rdy;
        bit          pt;
        bit          tk;
        logic [31:0] alt;
    } ent_t;

    typedef struct {
        int          kind;
        int          id;
        int          addr;
        logic [31:0] val;
    } ev_t;

    ent_t        rob[$];
    ev_t         sb[$];
    int          tail = 0;
    bit          flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    int          vectors = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ref_query(input int qid, output bit r,
                             output logic [31:0] v);
        r = 1'b0;
        v = 32'd0;
        if (cdbValid && int'(cdbId) == qid) begin
            r = 1'b1;
            v = cdbValue;
        end else begin
            foreach (rob[i])
                if (rob[i].id == qid && rob[i].rdy) begin
                    r = 1'b1;
                    v = rob[i].val;
                end
        end
    endtask

    // One clock of the reference model; called at the falling edge
    task automatic step();
        bit full, acc, ret, mis, qr;
        logic [31:0] qv;
        ent_t h, n;
        ev_t e;
        #1;
        full = (rob.size() == DEPTH);
        acc = issueValid && readyIn && !full && !flush;
        chk("issueAccept", 32'(issueAccept), 32'(acc));
        chk("robFull", 32'(robFull), 32'(full));
        chk("allocId", 32'(allocId), 32'(tail));
        ref_query(int'(query1Id), qr, qv);
        chk("query1Ready", 32'(query1Ready), 32'(qr));
        chk("query1Value", query1Value, qv);
        ref_query(int'(query2Id), qr, qv);
        chk("query2Ready", 32'(query2Ready), 32'(qr));
        chk("query2Value", query2Value, qv);
        if (flush) begin
            e = '{EV_CLEAR, 0, 0, flush_pc};
            sb.push_back(e);
        end
        ret = readyIn && !flush && rob.size() > 0 && rob[0].rdy;
        mis = 1'b0;
        if (ret) begin
            h = rob[0];
            if (h.typ == ROB_TYPE_REG) begin
                e = '{EV_REG, h.id, int'(h.rd), h.val};
                sb.push_back(e);
            end else if (h.typ == ROB_TYPE_STORE) begin
                e = '{EV_STORE, h.id, 0, 32'd0};
                sb.push_back(e);
            end else if (h.typ == ROB_TYPE_BRANCH) begin
                mis = (h.tk != h.pt);
            end
        end
        if (readyIn) begin
            if (flush) begin
                flush = 1'b0;
            end else if (mis) begin
                rob.delete();
                tail = 0;
                flush = 1'b1;
                flush_pc = h.alt;
            end else begin
                if (ret) void'(rob.pop_front());
                if (cdbValid)
                    foreach (rob[i])
                        if (rob[i].id == int'(cdbId)) begin
                            rob[i].rdy = 1'b1;
                            rob[i].val = cdbValue;
                            rob[i].tk = cdbTaken;
                        end
                if (acc) begin
                    n.id = tail;
                    n.typ = issueType;
                    n.rd = issueRd;
                    n.val = issueValue;
                    n.rdy = issueReadyNow || issueType == ROB_TYPE_NONE;
                    n.pt = issuePredTaken;
                    n.tk = 1'b0;
                    n.alt = issueAltPc;
                    rob.push_back(n);
                    tail = (tail + 1) % DEPTH;
                end
            end
        end
        vectors++;
        @(negedge clockIn);
    endtask

    task automatic idle();
        readyIn = 1'b1;
        issueValid = 1'b0;
        cdbValid = 1'b0;
        query1Id = 4'd0;
        query2Id = 4'd0;
    endtask

    task automatic issue(input logic [1:0] t, input int rd, input bit rn,
                         input logic [31:0] v, input bit pt,
                         input logic [31:0] alt);
        issueValid = 1'b1;
        issueType = t;
        issueRd = 5'(rd);
        issueReadyNow = rn;
        issueValue = v;
        issuePredTaken = pt;
        issueAltPc = alt;
    endtask

    task automatic cdb(input int id, input logic [31:0] v, input bit tk);
        cdbValid = 1'b1;
        cdbId = 4'(id);
        cdbValue = v;
        cdbTaken = tk;
    endtask

    task automatic do_reset();
        idle();
        resetIn = 1'b0;
        #3;
        chk("rst robFull", 32'(robFull), 32'd0);
        chk("rst allocId", 32'(allocId), 32'd0);
        chk("rst issueAccept", 32'(issueAccept), 32'd0);
        chk("rst writeFlag", 32'(writeFlag), 32'd0);
        chk("rst storeCommit", 32'(storeCommit), 32'd0);
        chk("rst clearOut", 32'(clearOut), 32'd0);
        chk("rst clearPc", clearPc, 32'd0);
        chk("rst query1Ready", 32'(query1Ready), 32'd0);
        rob.delete();
        sb.delete();
        tail = 0;
        flush = 1'b0;
        @(negedge clockIn);
        resetIn = 1'b1;
    endtask

    task automatic mon_take(input int kind, input int id, input int addr,
                            input logic [31:0] v);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected output kind %0d id %0d addr %0d value %h at %0t",
                     kind, id, addr, v, $time);
        end else begin
            e = sb.pop_front();
            chk("event kind", 32'(kind), 32'(e.kind));
            chk("event id", 32'(id), 32'(e.id));
            chk("event addr", 32'(addr), 32'(e.addr));
            chk("event value", v, e.val);
        end
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT strobes
    initial begin
        while (!done) begin
            @(negedge clockIn);
            #2;
            if (resetIn && !done) begin
                if (writeFlag)
                    mon_take(EV_REG, int'(robId), int'(writeAddr), writeValue);
                if (storeCommit)
                    mon_take(EV_STORE, int'(robId), 0, 32'd0);
                if (clearOut)
                    mon_take(EV_CLEAR, 0, 0, clearPc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic rand_cycle();
        int cand[$];
        idle();
        readyIn = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 1) == 1)
            issue(2'($urandom), $urandom_range(0, 31),
                  ($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
                  $urandom);
        foreach (rob[i]) if (!rob[i].rdy) cand.push_back(rob[i].id);
        if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
            int k;
            k = cand[$urandom_range(0, cand.size() - 1)];
            foreach (rob[i])
                if (rob[i].id == k)
                    cdb(k, $urandom,
                        ($urandom_range(0, 19) == 0) ? !rob[i].pt : rob[i].pt);
        end else if ($urandom_range(0, 4) == 0) begin
            cdb($urandom_range(0, 15), $urandom, 1'($urandom));
        end
        query1Id = 4'($urandom);
        query2Id = cdbValid ? cdbId : 4'($urandom);
        step();
    endtask

    initial begin
        int bid;
        @(negedge clockIn);
        do_reset();

        // 2: single REG through CDB to commit
        issue(ROB_TYPE_REG, 5, 0, 32'd0, 0, 32'd0);
        step();
        idle(); cdb(0, 32'h1234, 0); step();
        idle(); step(); step();

        // 1: reset in the middle of traffic
        issue(ROB_TYPE_REG, 7, 0, 32'd0, 0, 32'd0); step();
        issue(ROB_TYPE_STORE, 0, 0, 32'd0, 0, 32'd0); step();
        do_reset();
        idle(); step();

        // 3: fill, full, retire with issue, wrap
        for (int i = 0; i < 16; i++) begin
            idle(); issue(ROB_TYPE_REG, i + 1, 0, 32'(i), 0, 32'd0); step();
        end
        idle(); issue(ROB_TYPE_REG, 20, 0, 32'd0, 0, 32'd0); step();
        idle(); cdb(0, 32'hAAAA, 0); step();
        idle(); issue(ROB_TYPE_REG, 21, 1, 32'h55, 0, 32'd0); step();
        idle(); issue(ROB_TYPE_REG, 22, 1, 32'h66, 0, 32'd0); step();

        // 4: out-of-order CDB, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(ROB_TYPE_REG, i + 1, 0, 32'd0, 0, 32'd0); step();
        end
        idle(); cdb(2, 32'h22, 0); step();
        idle(); cdb(1, 32'h11, 0); step();
        idle(); cdb(0, 32'h00, 0); step();
        idle(); step(); step(); step(); step();

        // 5: mispredicted branch flushes younger entries
        bid = tail;
        idle(); issue(ROB_TYPE_BRANCH, 0, 0, 32'd0, 0, 32'h100); step();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(ROB_TYPE_REG, 9, 1, 32'(i + 7), 0, 32'd0); step();
        end
        idle(); cdb(bid, 32'd0, 1); step();
        idle(); issue(ROB_TYPE_REG, 3, 1, 32'h9, 0, 32'd0); step();
        idle(); issue(ROB_TYPE_REG, 4, 1, 32'hA, 0, 32'd0); step();
        idle(); step(); step();

        // 6: query bypass and hold
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); issue(ROB_TYPE_REG, i + 1, 0, 32'd0, 0, 32'd0); step();
        end
        idle(); readyIn = 1'b0; cdb(3, 32'hABCD, 0); query1Id = 4'd3;
        issue(ROB_TYPE_STORE, 0, 1, 32'd0, 0, 32'd0); step();
        idle(); readyIn = 1'b0; query1Id = 4'd3; step();
        idle(); cdb(0, 32'h77, 0); step();
        idle(); readyIn = 1'b0; step(); step();
        idle(); step(); step();

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            rand_cycle();
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            foreach (rob[j]) if (!rob[j].rdy) begin
                cdb(rob[j].id, 32'(j), rob[j].pt);
                break;
            end
            step();
            idle();
        end

        done = 1'b1;
        @(negedge clockIn);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, n_fail);
        $finish;
    end

endmodule
